// File: rtl/song_sequencer_if.sv
// Sequencer bus: control inputs, song ROM port and note-load outputs.
// master = song_sequencer side, slave = environment (ROM, distributor, control).
interface song_sequencer_if #(
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2
);
    logic                    play;
    logic                    beat;
    logic [SONG_W-1:0]       song;
    logic                    voice_free;
    logic [SONG_W+IDX_W-1:0] rom_addr;
    logic [15:0]             rom_data;
    logic                    load_new_note;
    logic [5:0]              note_to_load;
    logic [5:0]              duration_to_load;
    logic                    song_done;

    modport master (
        input  play, beat, song, voice_free, rom_data,
        output rom_addr, load_new_note, note_to_load,
        output duration_to_load, song_done
    );

    modport slave (
        output play, beat, song, voice_free, rom_data,
        input  rom_addr, load_new_note, note_to_load,
        input  duration_to_load, song_done
    );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks one song in the song ROM and issues notes/waits.
// Ports: clk, reset (async, active-high), bus (song_sequencer_if.master).
module song_sequencer #(
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    song_sequencer_if.master   bus
);

    localparam logic [2:0] S_FETCH    = 3'd0;
    localparam logic [2:0] S_ROM_WAIT = 3'd1;
    localparam logic [2:0] S_DECODE   = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [SONG_W-1:0]       song_q, song_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [5:0]              wait_q, wait_d;
    logic [SONG_W+IDX_W-1:0] addr_q, addr_d;
    logic [5:0]              note_q, note_d;
    logic [5:0]              dur_q, dur_d;

    logic [15:0] word;
    logic        is_end;
    logic        is_wait;
    logic [5:0]  beats;
    logic        song_chg;
    logic        last_idx;
    logic        load;
    logic        adv;

    assign word     = bus.rom_data;
    assign is_end   = (word == 16'h0000);
    assign is_wait  = word[15];
    assign beats    = word[5:0];
    assign song_chg = (bus.song != song_q);
    assign last_idx = (idx_q == {IDX_W{1'b1}});

    // Pulse is combinational in DECODE so it lands 2 cycles after FETCH.
    assign load = (state_q == S_DECODE) && bus.play && !song_chg
                  && !is_end && !is_wait && bus.voice_free;

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        note_d  = note_q;
        dur_d   = dur_q;
        adv     = 1'b0;
        if (song_chg) begin
            // Song change wins over everything, even while paused.
            song_d  = bus.song;
            idx_d   = '0;
            wait_d  = '0;
            addr_d  = {bus.song, {IDX_W{1'b0}}};
            state_d = S_FETCH;
        end else if (bus.play) begin
            unique case (state_q)
                S_FETCH: begin
                    addr_d  = {song_q, idx_q};
                    state_d = S_ROM_WAIT;
                end
                S_ROM_WAIT: begin
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (is_end) begin
                        state_d = S_DONE;
                    end else if (is_wait) begin
                        if (beats == 6'd0) begin
                            adv = 1'b1;
                        end else begin
                            wait_d  = beats;
                            state_d = S_WAIT;
                        end
                    end else if (load) begin
                        note_d = word[14:9];
                        dur_d  = word[8:3];
                        adv    = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.beat) begin
                        if (wait_q == 6'd1) begin
                            adv = 1'b1;
                        end else begin
                            wait_d = wait_q - 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
            // Stepping past the last word ends the song instead of wrapping.
            if (adv) begin
                if (last_idx) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            song_q  <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
        end
    end

    // Note/duration show the ROM word during the pulse, then the held copy.
    assign bus.rom_addr         = addr_q;
    assign bus.load_new_note    = load;
    assign bus.note_to_load     = load ? word[14:9] : note_q;
    assign bus.duration_to_load = load ? word[8:3] : dur_q;
    assign bus.song_done        = (state_q == S_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Testbench for song_sequencer: ROM model, directed stimulus and
// a scoreboard of expected note pulses (note, duration, cycle).
module tb_song_sequencer;

    typedef struct {
        logic [5:0] n;
        logic [5:0] d;
        int         c;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [15:0] mem [0:127];

    song_sequencer_if bus ();

    song_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Song ROM: one cycle read latency.
    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    function automatic logic [15:0] nw(input logic [5:0] n,
                                       input logic [5:0] d);
        return {1'b0, n, d, 3'b101};
    endfunction

    function automatic logic [15:0] wt(input logic [5:0] b);
        return {1'b1, 9'd0, b};
    endfunction

    task automatic push(input int n, input int d, input int c);
        exp_t e;
        e.n = 6'(n);
        e.d = 6'(d);
        e.c = c;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic beat_at(input int c);
        wait_to(c);
        bus.beat = 1'b1;
        @(negedge clk);
        bus.beat = 1'b0;
    endtask

    // Monitor: every load pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        #2;
        if (bus.load_new_note) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pulse: unexpected note %0d dur %0d cycle %0d",
                         bus.note_to_load, bus.duration_to_load, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.note_to_load != e.n || bus.duration_to_load != e.d
                    || cyc != e.c) begin
                    errors++;
                    $display("FAIL pulse: got note %0d dur %0d cycle %0d expected note %0d dur %0d cycle %0d",
                             bus.note_to_load, bus.duration_to_load, cyc,
                             e.n, e.d, e.c);
                end
            end
        end
    end

    initial begin
        int r, t, t2, t3;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        // Song 0: notes, stall, waits, pause, abandoned wait.
        mem[0] = nw(20, 8);
        mem[1] = nw(21, 9);
        mem[2] = wt(3);
        mem[3] = nw(22, 10);
        mem[4] = wt(0);
        mem[5] = nw(23, 11);
        mem[6] = wt(4);
        mem[7] = nw(24, 12);
        mem[8] = wt(5);
        mem[9] = nw(25, 13);
        // Song 1: end marker at idx5; idx3 is note 0/dur 0 (not an end).
        mem[32] = nw(40, 2);
        mem[33] = nw(41, 3);
        mem[34] = nw(42, 4);
        mem[35] = nw(0, 0);
        mem[36] = nw(44, 6);
        // Song 2: all 32 words are notes.
        for (int k = 0; k < 32; k++) mem[64+k] = nw(6'(k + 30), 6'(63 - k));
        // Song 3: max note at idx0, end at idx1.
        mem[96] = nw(63, 63);

        reset          = 1'b1;
        bus.play       = 1'b1;
        bus.beat       = 1'b0;
        bus.song       = 2'd0;
        bus.voice_free = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_addr", int'(bus.rom_addr), 0);
        chk("rst_load", int'(bus.load_new_note), 0);
        chk("rst_note", int'(bus.note_to_load), 0);
        chk("rst_dur", int'(bus.duration_to_load), 0);
        chk("rst_done", int'(bus.song_done), 0);
        @(negedge clk);
        reset = 1'b0;
        r = cyc;

        // T1..T5 on song 0.
        push(20, 8, r + 2);
        push(21, 9, r + 13);
        push(22, 10, r + 29);
        push(23, 11, r + 35);
        push(24, 12, r + 60);
        wait_to(r + 3);
        bus.voice_free = 1'b0;
        wait_to(r + 4);
        chk("t1_addr_idx1", int'(bus.rom_addr), 1);
        wait_to(r + 13);
        bus.voice_free = 1'b1;
        beat_at(r + 14);
        beat_at(r + 20);
        beat_at(r + 23);
        beat_at(r + 26);
        wait_to(r + 40);
        bus.play = 1'b0;
        beat_at(r + 41);
        beat_at(r + 43);
        beat_at(r + 45);
        beat_at(r + 47);
        wait_to(r + 48);
        chk("t5_addr_paused", int'(bus.rom_addr), 6);
        wait_to(r + 49);
        bus.play = 1'b1;
        beat_at(r + 51);
        beat_at(r + 53);
        beat_at(r + 55);
        beat_at(r + 57);

        // T6: song change 0->2 during a wait, then full 32-note song.
        beat_at(r + 66);
        wait_to(r + 68);
        bus.song = 2'd2;
        for (int k = 0; k < 32; k++) push(k + 30, 63 - k, r + 71 + 3 * k);
        wait_to(r + 69);
        chk("t6_addr_song2", int'(bus.rom_addr), 64);
        chk("t6_done_clr", int'(bus.song_done), 0);
        wait_to(r + 163);
        chk("t4_done_before_last", int'(bus.song_done), 0);
        wait_to(r + 166);
        chk("t4_wrap_done", int'(bus.song_done), 1);
        chk("t4_wrap_addr", int'(bus.rom_addr), 95);
        wait_to(r + 190);
        chk("t4_wrap_addr_held", int'(bus.rom_addr), 95);

        // T4: end marker in song 1.
        t = r + 190;
        bus.song = 2'd1;
        push(40, 2, t + 3);
        push(41, 3, t + 6);
        push(42, 4, t + 9);
        push(0, 0, t + 12);
        push(44, 6, t + 15);
        wait_to(t + 1);
        chk("t4_done_clr", int'(bus.song_done), 0);
        wait_to(t + 18);
        chk("t4_done_at_decode", int'(bus.song_done), 0);
        wait_to(t + 19);
        chk("t4_end_done", int'(bus.song_done), 1);

        // T6: reset asserted mid-stall on song 3.
        t2 = t + 30;
        wait_to(t2);
        bus.voice_free = 1'b0;
        bus.song       = 2'd3;
        wait_to(t2 + 6);
        chk("held_note", int'(bus.note_to_load), 44);
        chk("held_dur", int'(bus.duration_to_load), 6);
        reset = 1'b1;
        #1;
        chk("mid_rst_addr", int'(bus.rom_addr), 0);
        chk("mid_rst_load", int'(bus.load_new_note), 0);
        chk("mid_rst_note", int'(bus.note_to_load), 0);
        chk("mid_rst_dur", int'(bus.duration_to_load), 0);
        chk("mid_rst_done", int'(bus.song_done), 0);
        t3 = t2 + 9;
        wait_to(t3);
        bus.voice_free = 1'b1;
        push(63, 63, t3 + 3);
        reset = 1'b0;
        wait_to(t3 + 1);
        chk("post_rst_addr", int'(bus.rom_addr), 96);
        wait_to(t3 + 10);
        chk("post_rst_done", int'(bus.song_done), 1);
        repeat (3) @(negedge clk);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL pulse_missing: got none expected note %0d dur %0d cycle %0d",
                     e.n, e.d, e.c);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
